mf8_ram_arb: RTL and testbench

Arbiter/sequencer that shares one single-port synchronous data RAM between the mf8 core data port and a second host requester (debug/loader/DMA).
- Core side uses the level-held rd/wr plus ready handshake; the core stalls on ready.
- Host side uses a req/ack handshake.
- The block issues one access at a time, counts the RAM read latency, and returns data with a one-cycle response strobe.

---
 rtl/mf8_ram_arb_pkg.sv | 23 ++
 rtl/mf8_arb_prio.sv | 49 ++++
 rtl/mf8_ram_arb.sv | 122 ++++++++++++
 tb/tb_mf8_ram_arb.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mf8_ram_arb_pkg.sv
// Shared types and constants for the mf8 data-RAM arbiter.
// Optional host-fairness build: MF8_RAM_ARB_FAIR_EN.
package mf8_ram_arb_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RD_WAIT = 2'd1;
    localparam state_t ST_RESP    = 2'd2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    localparam int MEM_LAT_MAX = 3;
    localparam int LAT_W       = $clog2(MEM_LAT_MAX + 1);

    function automatic int starve_w(input int max_grants);
        return (max_grants < 2) ? 1 : $clog2(max_grants + 1);
    endfunction

endpackage

// File: rtl/mf8_arb_prio.sv
// Winner select between core and host; core wins unless the host has been starved.
// Starve counter exists only when MF8_RAM_ARB_FAIR_EN is defined.
module mf8_arb_prio
    import mf8_ram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
`ifdef MF8_RAM_ARB_FAIR_EN
    input  logic Clk,
    input  logic Reset_n,
`endif
    input  logic arb_en,
    input  logic c_pend,
    input  logic h_pend,
    output logic grant_core,
    output logic grant_host
);

`ifdef MF8_RAM_ARB_FAIR_EN
    localparam int SW = starve_w(STARVE_MAX);

    logic [SW-1:0] starve_cnt;
    logic          starved;

    assign starved    = (starve_cnt == SW'(STARVE_MAX));
    assign grant_host = arb_en & h_pend & (~c_pend | starved);
    assign grant_core = arb_en & c_pend & ~(h_pend & starved);

    // Counts core grants the host sat through; any host grant or idle host clears it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            starve_cnt <= '0;
        end else if (arb_en) begin
            if (!h_pend || grant_host) begin
                starve_cnt <= '0;
            end else if (grant_core && !starved) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (STARVE_MAX > 0);

    assign grant_core = arb_en & c_pend;
    assign grant_host = arb_en & h_pend & ~c_pend;
`endif

endmodule

// File: rtl/mf8_ram_arb.sv
// Shares one single-port sync RAM between the mf8 core data port and a host port.
// One access in flight; optional host anti-starvation via MF8_RAM_ARB_FAIR_EN.
module mf8_ram_arb
    import mf8_ram_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [15:0]       c_addr,
    input  logic              c_rd,
    input  logic              c_wr,
    input  logic [7:0]        c_wdata,
    output logic [7:0]        c_rdata,
    output logic              c_ready,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [15:0]       h_addr,
    input  logic [7:0]        h_wdata,
    output logic              h_ack,
    output logic [7:0]        h_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [7:0]        m_wdata,
    input  logic [7:0]        m_rdata
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    state_t           state;
    owner_t           owner;
    logic             rd_op;
    logic [LAT_W-1:0] lat_cnt;

    logic arb_en;
    logic grant_core;
    logic grant_host;
    logic issue;
    logic issue_we;

    // Reset gates the issue path so every output is quiet while Reset_n is low.
    assign arb_en = (state == ST_IDLE) & Reset_n;

    mf8_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
`ifdef MF8_RAM_ARB_FAIR_EN
        .Clk        (Clk),
        .Reset_n    (Reset_n),
`endif
        .arb_en     (arb_en),
        .c_pend     (c_rd | c_wr),
        .h_pend     (h_req),
        .grant_core (grant_core),
        .grant_host (grant_host)
    );

    assign issue    = grant_core | grant_host;
    assign issue_we = grant_core ? c_wr : h_we;

    always_comb begin
        m_en    = issue;
        m_we    = issue & issue_we;
        m_addr  = '0;
        m_wdata = '0;
        if (grant_core) begin
            m_addr  = c_addr[ADDR_W-1:0];
            m_wdata = c_wdata;
        end else if (grant_host) begin
            m_addr  = h_addr[ADDR_W-1:0];
            m_wdata = h_wdata;
        end
    end

    logic unused_hi_addr;
    assign unused_hi_addr = ^{c_addr[15:ADDR_W], h_addr[15:ADDR_W]};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_IDLE;
            owner   <= OWN_NONE;
            rd_op   <= 1'b0;
            lat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        owner <= grant_core ? OWN_CORE : OWN_HOST;
                        rd_op <= ~issue_we;
                        if (issue_we) begin
                            state <= ST_RESP;
                        end else begin
                            lat_cnt <= LAT_LOAD;
                            state   <= (MEM_LAT > 1) ? ST_RD_WAIT : ST_RESP;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (lat_cnt == LAT_W'(1)) begin
                        state <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign c_ready = (state == ST_RESP) && (owner == OWN_CORE);
    assign h_ack   = (state == ST_RESP) && (owner == OWN_HOST);
    assign c_rdata = (c_ready && rd_op) ? m_rdata : 8'h00;
    assign h_rdata = (h_ack && rd_op) ? m_rdata : 8'h00;

endmodule

// File: tb/tb_mf8_ram_arb.sv
// Randomized bench for mf8_ram_arb with a transaction-level arbitration/timing model and RAM scoreboard.
module tb_mf8_ram_arb;

    localparam int ADDR_W     = 10;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
`ifdef MF8_RAM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic [15:0]       c_addr;
    logic              c_rd, c_wr;
    logic [7:0]        c_wdata, c_rdata;
    logic              c_ready;
    logic              h_req, h_we;
    logic [15:0]       h_addr;
    logic [7:0]        h_wdata, h_rdata;
    logic              h_ack;
    logic              m_en, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_wdata, m_rdata;

    mf8_ram_arb #(
        .ADDR_W     (ADDR_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .c_addr  (c_addr),
        .c_rd    (c_rd),
        .c_wr    (c_wr),
        .c_wdata (c_wdata),
        .c_rdata (c_rdata),
        .c_ready (c_ready),
        .h_req   (h_req),
        .h_we    (h_we),
        .h_addr  (h_addr),
        .h_wdata (h_wdata),
        .h_ack   (h_ack),
        .h_rdata (h_rdata),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // RAM with MEM_LAT cycles of read latency.
    logic [7:0] mem [1024];
    logic [7:0] pipe [MEM_LAT];
    bit         mem_ready = 1'b0;
    assign m_rdata = pipe[MEM_LAT-1];

    always @(posedge Clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 37 + 5);
            mem_ready <= 1'b1;
        end else if (m_en && m_we) begin
            mem[m_addr] <= m_wdata;
        end
        pipe[0] <= mem[m_addr];
        for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
    end

    logic [7:0] ref_mem [1024];

    // Monitor: serial issue, exact completion cycle, owner of each strobe, winner choice.
    typedef struct { int due; bit host; } pend_t;
    pend_t q[$];
    pend_t p;
    int    streak = 0;
    bit    mon_on = 1'b0;
    bit    m_idle, m_cp, m_hp, m_hw, m_we_exp;
    logic [15:0] m_addr_exp;
    logic [7:0]  m_wd_exp;

    always @(negedge Clk) begin
        if (!mon_on || !Reset_n) begin
            q.delete();
            streak = 0;
        end else begin
            m_idle = (q.size() == 0);
            m_cp   = c_rd | c_wr;
            m_hp   = h_req;
            if (q.size() > 0 && q[0].due == cyc) begin
                check("strobe_owner", {c_ready, h_ack}, q[0].host ? 2'b01 : 2'b10);
                void'(q.pop_front());
            end else begin
                check("no_strobe", {c_ready, h_ack}, 2'b00);
            end
            if (!c_ready) check("c_rdata_zero", c_rdata, 0);
            if (!h_ack)   check("h_rdata_zero", h_rdata, 0);
            if (m_idle) begin
                m_hw = m_hp && (!m_cp || (FAIR && streak == STARVE_MAX));
                check("arb_m_en", m_en, m_cp | m_hp);
                if (m_cp | m_hp) begin
                    m_we_exp   = m_hw ? h_we : c_wr;
                    m_addr_exp = m_hw ? h_addr : c_addr;
                    m_wd_exp   = m_hw ? h_wdata : c_wdata;
                    check("arb_m_we", m_we, m_we_exp);
                    check("arb_m_addr", m_addr, m_addr_exp % 1024);
                    if (m_we_exp) check("arb_m_wdata", m_wdata, m_wd_exp);
                    p.host = m_hw;
                    p.due  = cyc + (m_we_exp ? 1 : MEM_LAT);
                    q.push_back(p);
                    if (m_hw) streak = 0;
                    else if (m_hp) streak++;
                end
                if (!m_hp) streak = 0;
            end else begin
                check("busy_no_issue", m_en, 0);
            end
        end
    end

    task automatic core_xfer(input bit we, input logic [15:0] a, input logic [7:0] d,
                             output logic [7:0] rdv, output int lat, output int done_cyc);
        bit done = 1'b0;
        c_addr = a; c_wdata = d; c_wr = we; c_rd = !we;
        lat = -1; rdv = 8'h00; done_cyc = -1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge Clk);
            if (c_ready) begin
                done = 1'b1; lat = i; rdv = c_rdata; done_cyc = cyc;
            end
        end
        check("c_complete", done, 1);
        if (done) begin
            if (we) ref_mem[a[9:0]] = d;
            else    check("c_rdata", rdv, ref_mem[a[9:0]]);
        end
        @(posedge Clk); #1;
        c_rd = 1'b0; c_wr = 1'b0;
    endtask

    task automatic host_xfer(input bit we, input logic [15:0] a, input logic [7:0] d,
                             output logic [7:0] rdv, output int done_cyc);
        bit done = 1'b0;
        h_addr = a; h_wdata = d; h_we = we; h_req = 1'b1;
        rdv = 8'h00; done_cyc = -1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge Clk);
            if (h_ack) begin
                done = 1'b1; rdv = h_rdata; done_cyc = cyc;
            end
        end
        check("h_complete", done, 1);
        if (done) begin
            if (we) ref_mem[a[9:0]] = d;
            else    check("h_rdata", rdv, ref_mem[a[9:0]]);
        end
        @(posedge Clk); #1;
        h_req = 1'b0;
    endtask

    logic [7:0] rd_c, rd_h;
    int lat_c, dc, dh, ccnt, h_at, c_last, gap;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37 + 5);
        Reset_n = 1'b0;
        c_addr = 16'h0; c_rd = 1'b1; c_wr = 1'b0; c_wdata = 8'h0;
        h_req = 1'b0; h_we = 1'b0; h_addr = 16'h0; h_wdata = 8'h0;

        // Reset: outputs quiet even with a core request pending.
        repeat (3) @(posedge Clk);
        #2;
        check("rst_strobes", {c_ready, h_ack, m_en, m_we}, 0);
        check("rst_data", {c_rdata, h_rdata, m_wdata, 6'b0, m_addr}, 0);
        c_rd = 1'b0;
        @(posedge Clk); #3;
        Reset_n = 1'b1;
        mon_on  = 1'b1;
        @(posedge Clk); #1;

        // Core write then read back, with issue-cycle bus check.
        fork
            core_xfer(1'b1, 16'h0012, 8'hA5, rd_c, lat_c, dc);
            begin
                @(negedge Clk);
                check("t1_issue", {m_en, m_we}, 2'b11);
                check("t1_addr", m_addr, 10'h012);
                check("t1_wdata", m_wdata, 8'hA5);
            end
        join
        check("t1_wr_lat", lat_c, 1);
        core_xfer(1'b0, 16'h0012, 8'h00, rd_c, lat_c, dc);
        check("t1_rd_lat", lat_c, MEM_LAT);
        check("t1_rd_data", rd_c, 8'hA5);

        // Simultaneous core and host reads: core first, host right after.
        host_xfer(1'b1, 16'h0040, 8'h3C, rd_h, dh);
        fork
            core_xfer(1'b0, 16'h0100, 8'h00, rd_c, lat_c, dc);
            host_xfer(1'b0, 16'h0040, 8'h00, rd_h, dh);
        join
        check("t2_core_first", dc < dh, 1);
        check("t2_host_gap", dh - dc, 1 + MEM_LAT);
        check("t2_h_data", rd_h, 8'h3C);

        // Core streams writes while host holds a read request.
        ccnt = 0; h_at = -1; c_last = -1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    core_xfer(1'b1, {6'($urandom), 10'h200 + 10'(i)}, 8'($urandom), rd_c, lat_c, c_last);
                    ccnt++;
                end
            end
            begin
                host_xfer(1'b0, 16'h0040, 8'h00, rd_h, dh);
                h_at = ccnt;
            end
        join
        check("t3_core_before_host", h_at, FAIR ? STARVE_MAX : 8);
        if (!FAIR) check("t4_host_after_drop", dh - c_last, 1 + MEM_LAT);

        // Reset during read latency: no completion for the aborted access.
        c_addr = 16'h0077; c_rd = 1'b1;
        @(negedge Clk);
        @(posedge Clk); #1;
        mon_on  = 1'b0;
        Reset_n = 1'b0;
        #1;
        check("t5_rst_strobes", {c_ready, h_ack, m_en, m_we}, 0);
        check("t5_rst_data", {c_rdata, h_rdata, m_wdata, 6'b0, m_addr}, 0);
        #1 c_rd = 1'b0;
        @(posedge Clk); #3;
        Reset_n = 1'b1;
        mon_on  = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            check("t5_no_ready", c_ready, 0);
        end
        @(posedge Clk); #1;
        core_xfer(1'b0, 16'h0077, 8'h00, rd_c, lat_c, dc);
        check("t5_next_lat", lat_c, MEM_LAT);

        // Upper address bits alias.
        host_xfer(1'b1, 16'h0412, 8'h5A, rd_h, dh);
        core_xfer(1'b0, 16'h0012, 8'h00, rd_c, lat_c, dc);
        check("t6_alias", rd_c, 8'h5A);

        // Random concurrent traffic on a small overlapping address set.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    core_xfer(1'($urandom), {6'($urandom), 6'd0, 4'($urandom)}, 8'($urandom), rd_c, lat_c, dc);
                    repeat ($urandom_range(0, 3)) begin @(posedge Clk); #1; end
                end
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    host_xfer(1'($urandom), {6'($urandom), 6'd0, 4'($urandom)}, 8'($urandom), rd_h, dh);
                    repeat ($urandom_range(0, 3)) begin @(posedge Clk); #1; end
                end
            end
        join

        repeat (4) @(posedge Clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
